// File: rtl/fir_requant_pkg.sv
// Shared defaults, saturation bounds and the stage-2 record for the FIR output requantizer.
package fir_requant_pkg;

    localparam int DEF_IN_W       = 64;
    localparam int DEF_OUT_W      = 16;
    localparam int DEF_SHIFT      = 15;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_CNT_W      = 16;

    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    // Data field is sized by DEF_OUT_W; the top must be built with OUT_W equal to it.
    typedef struct packed {
        logic                 valid;
        logic                 sat;
        logic [DEF_OUT_W-1:0] data;
    } s2_rec_t;

endpackage

// File: rtl/requant_fifo.sv
// Synchronous FIFO with registered storage; head is visible combinationally from the read slot.
// Push while full is ignored unless a pop happens the same cycle; pop while empty is ignored.
module requant_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [W-1:0]             i_push_dat,
    input  logic                     i_pop,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [W-1:0]             o_head_dat
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_pop;
    logic          w_push;

    assign o_full     = (r_count == (PW + 1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_head_dat = r_mem[r_rd_ptr];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (PW + 1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (PW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/fir_output_requant.sv
// Round-half-up shift and saturate FIR output to OUT_W, buffered in a FIFO; 3-cycle latency into an empty FIFO.
// Pipeline never stalls: a full FIFO without a same-cycle pop drops the sample and sets sticky overrun.
module fir_output_requant
    import fir_requant_pkg::*;
#(
    parameter int IN_W       = DEF_IN_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int SHIFT      = DEF_SHIFT,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  din,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] dout,
    output logic [CNT_W-1:0]        sat_count,
    output logic                    overrun,
    input  logic                    clear
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic signed [IN_W:0] RND =
        (SHIFT > 0) ? ((IN_W + 1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [IN_W:0] MAXV = (IN_W + 1)'(sat_max(OUT_W));
    localparam logic signed [IN_W:0] MINV = (IN_W + 1)'(sat_min(OUT_W));
    localparam logic [CNT_W-1:0]     CNT_MAX = '1;

    logic signed [IN_W:0] w_ext;
    logic signed [IN_W:0] w_rnd;
    logic signed [IN_W:0] w_shf;
    logic                 r_s1_vld;
    logic signed [IN_W:0] r_s1_dat;
    logic                 w_hi;
    logic                 w_lo;
    logic [OUT_W-1:0]     w_sat_dat;
    s2_rec_t              r_s2;
    logic                 w_full;
    logic                 w_empty;
    logic [PW:0]          w_count;
    logic [OUT_W-1:0]     w_head_dat;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic [CNT_W-1:0]     r_sat_count;
    logic                 r_overrun;

    // One guard bit above IN_W keeps the rounding add from wrapping.
    assign w_ext = {din[IN_W-1], din};
    assign w_rnd = w_ext + RND;
    assign w_shf = w_rnd >>> SHIFT;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s1_dat <= '0;
        end else begin
            r_s1_vld <= in_valid;
            r_s1_dat <= w_shf;
        end
    end

    assign w_hi = (r_s1_dat > MAXV);
    assign w_lo = (r_s1_dat < MINV);

    always_comb begin
        w_sat_dat = r_s1_dat[OUT_W-1:0];
        if (w_hi) begin
            w_sat_dat = MAXV[OUT_W-1:0];
        end else if (w_lo) begin
            w_sat_dat = MINV[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2 <= '0;
        end else begin
            r_s2 <= '{valid: r_s1_vld, sat: (w_hi || w_lo), data: w_sat_dat};
        end
    end

    assign w_pop  = out_ready && !w_empty;
    assign w_push = r_s2.valid && (!w_full || w_pop);
    assign w_drop = r_s2.valid && w_full && !w_pop;

    requant_fifo #(
        .W     (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_dat (r_s2.data),
        .i_pop      (w_pop),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count),
        .o_head_dat (w_head_dat)
    );

    // Saturations are counted at stage 2, so dropped samples still count.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_sat_count <= '0;
            r_overrun   <= 1'b0;
        end else begin
            if (r_s2.valid && r_s2.sat && (r_sat_count != CNT_MAX)) begin
                r_sat_count <= r_sat_count + CNT_W'(1);
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign out_valid = (w_count != '0);
    assign dout      = w_head_dat;
    assign sat_count = r_sat_count;
    assign overrun   = r_overrun;

endmodule

// File: doc/fir_output_requant.md
# fir_output_requant

Post-processing stage directly downstream of the pipelined FIR filter. It takes the filter's full-precision 64-bit signed accumulator output at the sample rate and rescales it to a 16-bit signed sample. Rescaling is a fixed right shift with round-half-up, followed by saturation. Results are buffered in a small FIFO behind a valid/ready handshake, so the consumer (DAC serializer, capture logic) may stall without blocking the free-running filter; drops and clips are reported through sticky status.

## Interface
- IN_W, 64, input width; matches FIR `dout`
- OUT_W, 16, output sample width
- SHIFT, 15, arithmetic right shift applied before saturation (0 ≤ SHIFT < IN_W)
- FIFO_DEPTH, 4, output buffer entries (power of two, ≥ 2)
- CNT_W, 16, saturation counter width
- clk  in  1  sample clock, shared with the FIR
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  `din` carries a new FIR output this cycle
- din  in  IN_W  signed FIR output
- out_valid  out  1  FIFO non-empty; `dout` valid
- out_ready  in  1  consumer accepts `dout` this cycle
- dout  out  OUT_W  signed requantized sample (FIFO head)
- sat_count  out  CNT_W  number of clipped samples, saturating
- overrun  out  1  sticky: at least one sample was dropped because the FIFO was full
- clear  in  1  synchronous clear of `sat_count` and `overrun`

## Operation
- **Stage 1 (round/shift):**
  - Sign-extend `din` to IN_W+1 bits.
  - Add 2^(SHIFT−1) when SHIFT > 0; add nothing when SHIFT = 0.
  - Arithmetic-shift right by SHIFT.
  - Register the result along with a valid bit. The extra bit prevents wrap on the rounding add.
- **Stage 2 (saturate):**
  - Values > 2^(OUT_W−1)−1 clamp to the max; values < −2^(OUT_W−1) clamp to the min.
  - Register the OUT_W-bit value, a valid bit and a sat flag.
- **FIFO push:** occurs when the stage-2 valid bit is set.
  - If full and no pop in the same cycle, the sample is dropped and `overrun` sets.
  - If full and a pop occurs in the same cycle, push and pop both happen and the count is unchanged.
- **FIFO pop:** occurs when `out_valid && out_ready`. `out_ready` while empty has no effect.
- **Push into an empty FIFO:** `out_valid` rises on the next edge. There is no same-cycle bypass.
- **Pointers:** wrap modulo FIFO_DEPTH. `out_valid = (count != 0)`.
- **`sat_count`:** increments once per stage-2 sample that saturated, including samples later dropped. It holds at 2^CNT_W−1 and never wraps.
- **`clear`:** takes priority over a same-cycle increment or overrun event. Result is `sat_count = 0` and `overrun = 0`.
- **No backpressure upstream:** the pipeline advances every cycle regardless of `out_ready`.
- **Reset:** `rst` at any time, including mid-stream, flushes both stage valids and empties the FIFO (pointers and count 0, storage zeroed). In-flight samples are discarded.
- **Reset values:** `out_valid = 0`, `dout = 0`, `sat_count = 0`, `overrun = 0`.

## Timing
- `in_valid` sampled on edge k:
  - stage 1 registered on edge k;
  - stage 2 registered on edge k+1;
  - written to the FIFO on edge k+2.
  - With the FIFO empty, `out_valid = 1` and the sample appears on `dout` after edge k+2, i.e. 3-cycle latency.
- Throughput: one sample per clock into the pipeline.
- `dout` changes only on a pop or on a push into an empty FIFO. It is stable while `out_valid && !out_ready`.
- `sat_count` updates on edge k+2 for a sample accepted on edge k. `overrun` sets on the same edge as the dropped push.
- First cycle after `rst` deasserts: `in_valid` is accepted normally.

## Structure
- Package `fir_requant_pkg`:
  - default parameter constants (IN_W, OUT_W, SHIFT, FIFO_DEPTH, CNT_W);
  - functions `sat_max(OUT_W)` and `sat_min(OUT_W)`;
  - a typedef for the stage-2 record {valid, sat, data}.
- One sub-module, `requant_fifo`: synchronous FIFO, width OUT_W, depth FIFO_DEPTH, sync active-high reset. Interface: push/pop/full/empty/count, plus head data output.
- Rounding, saturation and status counters live in the top-level module.

## Test plan
- **Rounding** (SHIFT=15, out_ready=1): each input gives the stated output, 3 cycles after input, with `sat_count` staying 0.
  - `din` = 3276800 → `dout` 100
  - `din` = 3293184 → `dout` 101 (exact half rounds up)
  - `din` = 3293183 → `dout` 100
  - `din` = −16384 → `dout` 0
  - `din` = −16385 → `dout` −1
- **Saturation:** `din` = 2^40 → 32767; `din` = −2^40 → −32768. `sat_count` reads 2. A 2^40 input with `clear` asserted on the edge where its count update would land → `sat_count` 0.
- **Backpressure/overrun:** out_ready=0, 6 consecutive valid samples 1..6 (scaled by 2^15).
  - Samples 1–4 are stored; 5 and 6 are dropped; `overrun` = 1.
  - Then out_ready=1 → `dout` shows 1, 2, 3, 4 on consecutive cycles, then `out_valid` = 0.
- **Full with simultaneous pop:** FIFO full, out_ready=1, continuous input → no drops, `overrun` stays 0, output streams in order at one sample per cycle.
- **Reset mid-stream:** assert `rst` one cycle while 2 samples are in the pipeline and 3 in the FIFO.
  - Next cycle: `out_valid` = 0, `dout` = 0, `sat_count` = 0, `overrun` = 0.
  - The first post-reset sample appears 3 cycles after acceptance.
- **Counter ceiling:** CNT_W=4, 20 saturating samples → `sat_count` holds 15.
